// File: rtl/core2wb_pipe_if.sv
// core2wb_pipe_if: core-side req/gnt/rvalid signals and Wishbone B4 pipelined master
// signals of one bridge instance; "master" is the bridge view, "slave" the core/bus view.
interface core2wb_pipe_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            core_req;
  logic            core_gnt;
  logic            core_we;
  logic [DW/8-1:0] core_be;
  logic [AW-1:0]   core_addr;
  logic [DW-1:0]   core_wdata;
  logic            core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic            core_err;

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            wb_stall_i;

  modport master (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    output core_gnt, core_rvalid, core_rdata, core_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output core_req, core_we, core_be, core_addr, core_wdata,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    input  core_gnt, core_rvalid, core_rdata, core_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/core2wb_pipe.sv
// core2wb_pipe: pipelined Ibex req/gnt/rvalid to Wishbone B4 bridge, up to MAX_OUTSTANDING in flight.
// Define CORE2WB_TIMEOUT_EN to add the bus watchdog and the ABORT drain state.
module core2wb_pipe #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT         = 256
) (
  input  logic           clk,
  input  logic           rst,
  core2wb_pipe_if.master bus
);

  localparam int unsigned   CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned   SW       = DW / 8;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef CORE2WB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
`endif

  state_e        state_r;
  state_e        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          rst_hold_r;
  logic          gate_s;
  logic          stb_s;
  logic          gnt_s;
  logic          rsp_s;
  logic          rvalid_s;
  logic          err_s;
  logic [DW-1:0] rdata_s;
  logic          cyc_s;

  // Outputs stay low while reset is applied and for the cycle right after it was sampled
  assign gate_s = rst || rst_hold_r;

  // Handshake decode for both sides of the bridge
  always_comb begin
    stb_s    = 1'b0;
    gnt_s    = 1'b0;
    rsp_s    = 1'b0;
    rvalid_s = 1'b0;
    err_s    = 1'b0;
    rdata_s  = {DW{1'b0}};
    cyc_s    = 1'b0;
    if (gate_s) begin
      stb_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, BUSY: begin
          stb_s    = bus.core_req && (cnt_r < CNT_MAX);
          gnt_s    = stb_s && !bus.wb_stall_i;
          // acks arriving with nothing outstanding are stale and dropped
          rsp_s    = (bus.wb_ack_i || bus.wb_err_i) && (cnt_r != CNT_ZERO);
          rvalid_s = rsp_s;
          err_s    = rsp_s && bus.wb_err_i;
          rdata_s  = bus.wb_dat_i;
          cyc_s    = stb_s || (cnt_r != CNT_ZERO);
        end
`ifdef CORE2WB_TIMEOUT_EN
        ABORT: begin
          // bus is released; every outstanding transfer gets a synthetic error
          rsp_s    = (cnt_r != CNT_ZERO);
          rvalid_s = rsp_s;
          err_s    = rsp_s;
        end
`endif
        default: begin
          stb_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.core_gnt    = gnt_s;
  assign bus.core_rvalid = rvalid_s;
  assign bus.core_rdata  = rdata_s;
  assign bus.core_err    = err_s;
  assign bus.wb_cyc_o    = cyc_s;
  assign bus.wb_stb_o    = stb_s;
  assign bus.wb_we_o     = stb_s && bus.core_we;
  assign bus.wb_sel_o    = stb_s ? bus.core_be    : {SW{1'b0}};
  assign bus.wb_adr_o    = stb_s ? bus.core_addr  : {AW{1'b0}};
  assign bus.wb_dat_o    = stb_s ? bus.core_wdata : {DW{1'b0}};

  // Outstanding count: a grant and a response in the same cycle cancel out
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (gnt_s && !rsp_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (!gnt_s && rsp_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

`ifdef CORE2WB_TIMEOUT_EN
  localparam int unsigned   WW      = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wd_r;
  logic          expire_s;

  assign expire_s = !gate_s && (state_r == BUSY) && (cnt_r != CNT_ZERO) &&
                    !rsp_s && (wd_r == WD_LAST);

  // Watchdog: counts busy cycles since the last response, restarts on any response
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= {WW{1'b0}};
    end else if ((state_r != BUSY) || rsp_s || (cnt_r == CNT_ZERO)) begin
      wd_r <= {WW{1'b0}};
    end else if (wd_r != WD_LAST) begin
      wd_r <= wd_r + WW'(1);
    end else begin
      wd_r <= wd_r;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 32'd1);
`endif

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_s && !rsp_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
`ifdef CORE2WB_TIMEOUT_EN
        if (expire_s) begin
          state_nxt_s = ABORT;
        end else
`endif
        if (cnt_nxt_s == CNT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
`ifdef CORE2WB_TIMEOUT_EN
      ABORT: begin
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ABORT;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, outstanding count and post-reset gating flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      rst_hold_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      rst_hold_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core2wb_pipe.sv
// Directed bench for core2wb_pipe: single read, full pipe, stall, gnt/ack overlap,
// spurious ack, reset mid-flight and (when CORE2WB_TIMEOUT_EN is defined) watchdog abort.
module tb_core2wb_pipe;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXO = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;

  core2wb_pipe_if #(.AW(AW), .DW(DW)) bus ();

  core2wb_pipe #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_be    = 4'h0;
    bus.core_addr  = 32'h0;
    bus.core_wdata = 32'h0;
    bus.wb_dat_i   = 32'h0;
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_stall_i = 1'b0;
  endtask

  function automatic logic [127:0] outs();
    return {22'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o,
            bus.wb_dat_o, bus.core_gnt, bus.core_rvalid, bus.core_rdata, bus.core_err};
  endfunction

  initial begin
    int issued, got, gnt_pre, max_cnt, exp_rd, k;
    bit first_rsp, full_seen, stb_full;
    int due[$];
    int dval[$];

    // reset with a pending request: everything gated low
    idle_inputs();
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h10;
    rst = 1'b1;
    tick(); tick(); settle();
    check("reset_outs", outs(), 128'h0);
    check("reset_cnt", 128'(dut.cnt_r), 128'd0);
    rst = 1'b0; bus.core_req = 1'b0;
    tick();

    // single read at 0x100, ack one cycle after the strobe
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h100;
    settle();
    check("t1_bus", 128'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o}),
          128'({1'b1, 1'b1, 1'b0, 4'hf, 32'h100}));
    check("t1_gnt", 128'(bus.core_gnt), 128'd1);
    check("t1_cnt0", 128'(dut.cnt_r), 128'd0);
    tick();
    idle_inputs();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
    settle();
    check("t1_cnt1", 128'(dut.cnt_r), 128'd1);
    check("t1_rsp", 128'({bus.core_rvalid, bus.core_err, bus.core_rdata}), 128'({1'b1, 1'b0, 32'hDEADBEEF}));
    tick();
    idle_inputs();
    settle();
    check("t1_after", 128'({bus.wb_cyc_o, bus.core_rvalid, dut.cnt_r}), 128'd0);
    tick();

    // six back-to-back reads, slave answers 4 cycles after each grant
    issued = 0; got = 0; gnt_pre = 0; max_cnt = 0; exp_rd = 1;
    first_rsp = 1'b0; full_seen = 1'b0; stb_full = 1'b0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      bus.core_req = (issued < 6); bus.core_be = 4'hf; bus.core_addr = 32'(issued * 4);
      if (due.size() > 0 && due[0] == c) begin
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'(dval[0]);
      end else begin
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
      end
      settle();
      if (int'(dut.cnt_r) > max_cnt) max_cnt = int'(dut.cnt_r);
      if (int'(dut.cnt_r) == MAXO) begin
        full_seen = 1'b1;
        if (bus.wb_stb_o) stb_full = 1'b1;
      end
      if (bus.core_rvalid) begin
        first_rsp = 1'b1;
        check("t2_rdata", 128'(bus.core_rdata), 128'(exp_rd));
        exp_rd++; got++;
      end
      if (bus.core_gnt) begin
        issued++;
        due.push_back(c + 4); dval.push_back(issued);
        if (!first_rsp) gnt_pre++;
      end
      if (bus.wb_ack_i) begin
        void'(due.pop_front()); void'(dval.pop_front());
      end
      tick();
    end
    idle_inputs();
    check("t2_rsp_count", 128'(got), 128'd6);
    check("t2_gnt_before_ack", 128'(gnt_pre), 128'd4);
    check("t2_max_cnt", 128'(max_cnt), 128'd4);
    check("t2_full_seen", 128'(full_seen), 128'd1);
    check("t2_stb_when_full", 128'(stb_full), 128'd0);

    // write held off by 5 stall cycles, granted in the 6th
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_be = 4'h3;
    bus.core_addr = 32'h40; bus.core_wdata = 32'h1234; bus.wb_stall_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      check("t3_stall_gnt", 128'(bus.core_gnt), 128'd0);
      check("t3_stall_bus", 128'({bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o}),
            128'({1'b1, 1'b1, 4'h3, 32'h40, 32'h1234}));
      tick();
    end
    bus.wb_stall_i = 1'b0;
    settle();
    check("t3_gnt6", 128'(bus.core_gnt), 128'd1);
    tick();
    idle_inputs();
    bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1;
    settle();
    check("t3_ack_err", 128'({bus.core_rvalid, bus.core_err}), 128'b11);
    tick();
    idle_inputs();
    settle();
    check("t3_cnt", 128'(dut.cnt_r), 128'd0);

    // grant and ack in the same cycle at cnt=2, then drain and a spurious ack
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h200;
    settle();
    check("t4_gnt_a", 128'(bus.core_gnt), 128'd1);
    tick();
    bus.core_addr = 32'h204;
    settle();
    check("t4_gnt_b", 128'(bus.core_gnt), 128'd1);
    tick();
    bus.core_addr = 32'h208; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h55;
    settle();
    check("t4_cnt_pre", 128'(dut.cnt_r), 128'd2);
    check("t4_gnt_ack", 128'({bus.core_gnt, bus.core_rvalid}), 128'b11);
    tick();
    check("t4_cnt_same", 128'(dut.cnt_r), 128'd2);
    bus.core_req = 1'b0; bus.core_addr = 32'h0;
    tick(); tick();
    settle();
    check("t4_spurious", 128'({bus.core_rvalid, bus.wb_cyc_o, dut.cnt_r}), 128'd0);
    tick();
    check("t4_cnt_zero", 128'(dut.cnt_r), 128'd0);
    idle_inputs();

`ifdef CORE2WB_TIMEOUT_EN
    // three reads never acknowledged: abort 8 cycles after the first grant
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h300;
    tick(); tick(); tick();
    idle_inputs();
    settle();
    check("t5_cnt3", 128'(dut.cnt_r), 128'd3);
    k = 0;
    while (!bus.core_rvalid && k < 20) begin
      tick(); settle(); k++;
    end
    check("t5_expiry_delay", 128'(k), 128'd6);
    check("t5_rsp1", 128'({bus.core_rvalid, bus.core_err, bus.core_rdata, bus.wb_cyc_o}), 128'({1'b1, 1'b1, 32'h0, 1'b0}));
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hABCD;
    settle();
    check("t5_rsp2_ack_ignored", 128'({bus.core_rvalid, bus.core_err, bus.core_rdata, bus.wb_cyc_o, bus.wb_stb_o}),
          128'({1'b1, 1'b1, 32'h0, 1'b0, 1'b0}));
    tick();
    idle_inputs();
    settle();
    check("t5_rsp3", 128'({bus.core_rvalid, bus.core_err}), 128'b11);
    tick();
    settle();
    check("t5_done", 128'({bus.core_rvalid, bus.wb_cyc_o, dut.cnt_r}), 128'd0);
`endif

    // reset with three transfers in flight
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h400;
    tick(); tick(); tick();
    check("t6_cnt3", 128'(dut.cnt_r), 128'd3);
    rst = 1'b1;
    tick();
    settle();
    check("t6_outs", outs(), 128'h0);
    check("t6_cnt0", 128'(dut.cnt_r), 128'd0);
    rst = 1'b0;
    tick();
    bus.core_req = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1;
    settle();
    check("t6_late_ack", 128'(bus.core_rvalid), 128'd0);
    tick();
    idle_inputs();
    bus.core_req = 1'b1; bus.core_be = 4'hf; bus.core_addr = 32'h404;
    settle();
    check("t6_regrant", 128'(bus.core_gnt), 128'd1);
    tick();
    idle_inputs();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h77;
    settle();
    check("t6_rsp", 128'({bus.core_rvalid, bus.core_rdata}), 128'({1'b1, 32'h77}));
    tick();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
